// File: rtl/fm_pkg.sv
// Shared constants, enums and helpers for the FM parameter loader.
// No logic; compile-time definitions only.
// Imported by the loader top and its switch conditioning sub-module.
package fm_pkg;

    localparam int NUM_OSC  = 4;
    localparam int WAVE_W   = 2;
    localparam int WEIGHT_W = 8;
    localparam int SW_W     = 10;

    typedef enum logic [1:0] {
        SINE     = 2'd0,
        SQUARE   = 2'd1,
        SAW      = 2'd2,
        TRIANGLE = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAVE   = 2'd1,
        S_SEL    = 2'd2,
        S_WEIGHT = 2'd3
    } ld_state_t;

    // Board switches are numbered high-to-low across oscillators: the MSB of
    // a 4-bit switch group selects osc0, the LSB selects osc3.
    function automatic logic [3:0] sw_to_mask(input logic [3:0] grp);
        return {grp[0], grp[1], grp[2], grp[3]};
    endfunction

    // Strobe arbitration shared by IDLE and every state exit:
    // weights beat enables beat waves.
    function automatic ld_state_t pick_next(input logic lw, input logic le, input logic lwt);
        if (lwt)      return S_WEIGHT;
        else if (le)  return S_SEL;
        else if (lw)  return S_WAVE;
        else          return S_IDLE;
    endfunction

endpackage

// File: rtl/sw_sync_debounce.sv
// Two-flop synchronizer for the raw board switches, optional stability qualifier.
// Latency: 2 cycles to sw_s; sw_stable follows DEBOUNCE_CYCLES later when enabled.
// No backpressure; free-running. Optional feature macro: FM_SW_DEBOUNCE_EN.
module sw_sync_debounce
    import fm_pkg::*;
`ifdef FM_SW_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 1024
)
`endif
(
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [SW_W-1:0] sw_raw,
    output logic [SW_W-1:0] sw_s,
    output logic            sw_stable
);

    logic [SW_W-1:0] sync1;

    // Metastability guard: two back-to-back flops on the asynchronous switches.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= '0;
            sw_s  <= '0;
        end else begin
            sync1 <= sw_raw;
            sw_s  <= sync1;
        end
    end

`ifdef FM_SW_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SW_W-1:0]  sw_prev;
    logic [CNT_W-1:0] cnt;

    // Count cycles of unchanged sw_s; any change restarts the window, saturate at the limit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sw_prev <= '0;
            cnt     <= '0;
        end else begin
            sw_prev <= sw_s;
            if (sw_s != sw_prev)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign sw_stable = (cnt == CNT_MAX);
`else
    assign sw_stable = 1'b1;
`endif

endmodule

// File: rtl/fm_param_loader.sv
// FM parameter bank: stages switches during controller strobes, commits waveform selects and weights on strobe release.
// Latency: commit on the edge the strobe is seen low; param_update the following cycle; SW->stg 3 edges.
// No backpressure; strobes not matching the current state wait until it exits. Optional macro: FM_SW_DEBOUNCE_EN.
module fm_param_loader
    import fm_pkg::*;
`ifdef FM_SW_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 1024
)
`endif
(
    input  logic                                 Clk,
    input  logic                                 Reset_n,
    input  logic                                 load_waves,
    input  logic                                 load_enables,
    input  logic                                 load_weights,
    input  logic [SW_W-1:0]                      SW,
    output logic [NUM_OSC*WAVE_W-1:0]            wave_sel,
    output logic [NUM_OSC*NUM_OSC*WEIGHT_W-1:0]  fm_weight,
    output logic [NUM_OSC-1:0]                   osc_sel_q,
    output logic [NUM_OSC-1:0]                   src_sel_q,
    output logic                                 param_update,
    output logic                                 busy
);

    ld_state_t         state;
    ld_state_t         nxt_idle;
    logic [SW_W-1:0]   sw_s;
    logic              sw_stable;
    logic [SW_W-1:0]   stg;
    logic [NUM_OSC-1:0] osc_mask;
    logic [NUM_OSC-1:0] src_mask;

    sw_sync_debounce
`ifdef FM_SW_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
        u_sw (
            .Clk       (Clk),
            .Reset_n   (Reset_n),
            .sw_raw    (SW),
            .sw_s      (sw_s),
            .sw_stable (sw_stable)
        );

    assign osc_mask = sw_to_mask(stg[9:6]);
    assign src_mask = sw_to_mask(stg[5:2]);
    assign nxt_idle = pick_next(load_waves, load_enables, load_weights);

    // Staging register tracks the conditioned switches only while a load is in progress.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            stg <= '0;
        else if (state != S_IDLE && sw_stable)
            stg <= sw_s;
    end

    // Loader FSM and register bank; every state exit re-arbitrates so handoffs cost no cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            wave_sel     <= '0;
            fm_weight    <= '0;
            osc_sel_q    <= '0;
            src_sel_q    <= '0;
            param_update <= 1'b0;
            busy         <= 1'b0;
        end else begin
            param_update <= 1'b0;
            case (state)
                S_IDLE: begin
                    state <= nxt_idle;
                    busy  <= (nxt_idle != S_IDLE);
                end
                S_WAVE: begin
                    if (!load_waves) begin
                        for (int i = 0; i < NUM_OSC; i++) begin
                            if (osc_mask[i])
                                wave_sel[i*WAVE_W +: WAVE_W] <= stg[WAVE_W-1:0];
                        end
                        param_update <= |osc_mask;
                        state        <= nxt_idle;
                        busy         <= (nxt_idle != S_IDLE);
                    end
                end
                S_SEL: begin
                    if (!load_enables) begin
                        osc_sel_q <= osc_mask;
                        src_sel_q <= src_mask;
                        state     <= nxt_idle;
                        busy      <= (nxt_idle != S_IDLE);
                    end
                end
                S_WEIGHT: begin
                    if (!load_weights) begin
                        for (int i = 0; i < NUM_OSC; i++) begin
                            for (int j = 0; j < NUM_OSC; j++) begin
                                if (osc_sel_q[i] && src_sel_q[j])
                                    fm_weight[(i*NUM_OSC+j)*WEIGHT_W +: WEIGHT_W] <= stg[WEIGHT_W-1:0];
                            end
                        end
                        param_update <= (|osc_sel_q) && (|src_sel_q);
                        state        <= nxt_idle;
                        busy         <= (nxt_idle != S_IDLE);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fm_param_loader.sv
// Directed bench for fm_param_loader: table of strobe loads plus handoff and reset-abort sequences.
// Inputs driven and outputs sampled 1 ns after the rising edge.
// Default build (switch debounce disabled).
module tb_fm_param_loader;
    import fm_pkg::*;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         load_waves = 1'b0;
    logic         load_enables = 1'b0;
    logic         load_weights = 1'b0;
    logic [9:0]   SW = '0;
    logic [7:0]   wave_sel;
    logic [127:0] fm_weight;
    logic [3:0]   osc_sel_q;
    logic [3:0]   src_sel_q;
    logic         param_update;
    logic         busy;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    fm_param_loader dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .load_waves   (load_waves),
        .load_enables (load_enables),
        .load_weights (load_weights),
        .SW           (SW),
        .wave_sel     (wave_sel),
        .fm_weight    (fm_weight),
        .osc_sel_q    (osc_sel_q),
        .src_sel_q    (src_sel_q),
        .param_update (param_update),
        .busy         (busy)
    );

    typedef struct {
        int           kind;       // 0 waves, 1 enables, 2 weights
        logic [9:0]   sw;
        int           hold;       // edges the strobe is high (>= 2)
        logic [7:0]   exp_wave;
        logic [3:0]   exp_osc;
        logic [3:0]   exp_src;
        logic [127:0] exp_wt;
        logic         exp_pulse;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    logic [127:0] wt_a;
    logic [127:0] wt_b;
    logic [127:0] wt_c;

    initial begin
        wt_a = 128'h3C;
        wt_b = wt_a | (128'hA5A5 << 48);
        wt_c = wt_b | (128'h5A << 120);

        vecs[0]  = '{0, 10'b0000000011, 3, 8'h00, 4'b0000, 4'b0000, 128'h0, 1'b0};
        vecs[1]  = '{0, 10'b1010000010, 5, 8'h22, 4'b0000, 4'b0000, 128'h0, 1'b1};
        vecs[2]  = '{0, 10'b0101000011, 2, 8'hEE, 4'b0000, 4'b0000, 128'h0, 1'b1};
        vecs[3]  = '{0, 10'b1000000001, 4, 8'hED, 4'b0000, 4'b0000, 128'h0, 1'b1};
        vecs[4]  = '{0, 10'b1111000000, 3, 8'h00, 4'b0000, 4'b0000, 128'h0, 1'b1};
        vecs[5]  = '{1, 10'b1000100000, 3, 8'h00, 4'b0001, 4'b0001, 128'h0, 1'b0};
        vecs[6]  = '{2, 10'h03C,        3, 8'h00, 4'b0001, 4'b0001, wt_a,   1'b1};
        vecs[7]  = '{1, 10'b0100001100, 3, 8'h00, 4'b0010, 4'b1100, wt_a,   1'b0};
        vecs[8]  = '{2, 10'h0A5,        5, 8'h00, 4'b0010, 4'b1100, wt_b,   1'b1};
        vecs[9]  = '{1, 10'b0000000000, 2, 8'h00, 4'b0000, 4'b0000, wt_b,   1'b0};
        vecs[10] = '{2, 10'h0FF,        3, 8'h00, 4'b0000, 4'b0000, wt_b,   1'b0};

        // Reset state
        tick(2);
        chk("rst_wave_sel", wave_sel, 0);
        chk("rst_fm_weight", fm_weight, 0);
        chk("rst_osc_sel", osc_sel_q, 0);
        chk("rst_src_sel", src_sel_q, 0);
        chk("rst_param_update", param_update, 0);
        chk("rst_busy", busy, 0);
        Reset_n = 1'b1;
        tick(2);

        // Table of single loads
        for (int k = 0; k < 11; k++) begin
            SW = vecs[k].sw;
            tick(3);
            case (vecs[k].kind)
                0:       load_waves = 1'b1;
                1:       load_enables = 1'b1;
                default: load_weights = 1'b1;
            endcase
            tick(1);
            chk($sformatf("v%0d_busy_entry", k), busy, 1);
            tick(vecs[k].hold - 1);
            load_waves = 1'b0;
            load_enables = 1'b0;
            load_weights = 1'b0;
            tick(1);
            chk($sformatf("v%0d_wave_sel", k), wave_sel, vecs[k].exp_wave);
            chk($sformatf("v%0d_osc_sel", k), osc_sel_q, vecs[k].exp_osc);
            chk($sformatf("v%0d_src_sel", k), src_sel_q, vecs[k].exp_src);
            chk($sformatf("v%0d_fm_weight", k), fm_weight, vecs[k].exp_wt);
            chk($sformatf("v%0d_param_update", k), param_update, vecs[k].exp_pulse);
            chk($sformatf("v%0d_busy_exit", k), busy, 0);
            tick(1);
            chk($sformatf("v%0d_pulse_end", k), param_update, 0);
        end

        // Direct handoffs WAVE->SEL->WEIGHT with no IDLE cycle
        SW = 10'b0010000001;
        tick(3);
        load_waves = 1'b1;
        tick(4);
        load_waves = 1'b0;
        load_enables = 1'b1;
        tick(1);
        chk("ho_wave_sel", wave_sel, 8'h10);
        chk("ho_wave_pulse", param_update, 1);
        chk("ho_busy_sel", busy, 1);
        SW = 10'b0001000100;
        tick(5);
        chk("ho_sel_no_pulse", param_update, 0);
        load_enables = 1'b0;
        load_weights = 1'b1;
        tick(1);
        chk("ho_osc_sel", osc_sel_q, 4'b1000);
        chk("ho_src_sel", src_sel_q, 4'b1000);
        chk("ho_busy_weight", busy, 1);
        chk("ho_sel_commit_no_pulse", param_update, 0);
        SW = 10'h05A;
        tick(5);
        load_weights = 1'b0;
        tick(1);
        chk("ho_fm_weight", fm_weight, wt_c);
        chk("ho_weight_pulse", param_update, 1);
        chk("ho_busy_done", busy, 0);
        tick(2);

        // Asynchronous reset in WEIGHT with staged data: nothing committed
        SW = 10'h077;
        tick(3);
        load_weights = 1'b1;
        tick(5);
        chk("ar_busy_before", busy, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("ar_wave_sel", wave_sel, 0);
        chk("ar_fm_weight", fm_weight, 0);
        chk("ar_osc_sel", osc_sel_q, 0);
        chk("ar_src_sel", src_sel_q, 0);
        chk("ar_param_update", param_update, 0);
        chk("ar_busy", busy, 0);
        load_weights = 1'b0;
        tick(2);
        Reset_n = 1'b1;
        tick(3);
        chk("ar_post_fm_weight", fm_weight, 0);
        chk("ar_post_pulse", param_update, 0);
        chk("ar_post_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
